vfu_slot_scheduler: RTL and testbench
=====================================

Name: vfu_slot_scheduler

Overview:
- Shares one vector functional unit (VFU) request port among NUM_SLOTS lane slot requesters.
- Arbitrates round-robin, caps in-flight requests per slot, and registers the winning request into a one-entry output stage towards the VFU.
- Stamps each request with the originating slot tag and steers VFU responses back to that slot.
- Sits between the lane slot control logic and the VFU's decoupled request interface; replaces the single-input pass-through arbiter when more than one slot targets a unit.

Parameters:
- NUM_SLOTS, 4, number of requesting slots (2..8).
- REQ_W, 200, width of the flattened slot request payload (src operands, opcode, masks, control bits).
- RESP_W, 33, width of the VFU response data.
- MAX_OUT, 2, maximum in-flight requests per slot (1..7).
- TAG_W, max(1, clog2(NUM_SLOTS)), slot tag width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_SLOTS  per-slot request valid.
- req_ready  out  NUM_SLOTS  per-slot request accept.
- req_bits  in  NUM_SLOTS*REQ_W  per-slot payload; slot i occupies bits [i*REQ_W +: REQ_W].
- vfu_valid  out  1  request to VFU valid.
- vfu_ready  in  1  VFU accepts request.
- vfu_bits  out  REQ_W  registered payload.
- vfu_tag  out  TAG_W  registered slot index.
- resp_valid  in  1  VFU response valid; no backpressure.
- resp_tag  in  TAG_W  slot index of the response.
- resp_data  in  RESP_W  response data.
- slot_resp_valid  out  NUM_SLOTS  one-hot response strobe.
- slot_resp_data  out  RESP_W  resp_data broadcast to all slots.
- idle  out  1  no in-flight or buffered requests.
- tag_err  out  1  sticky: response arrived for a slot with zero in-flight count.

Behaviour:
- Reset (reset==0 at clock edge) clears the following:
  - out_valid=0, out_bits=0, out_tag=0.
  - rr_ptr=0 (highest-priority slot).
  - all outstanding[i]=0.
  - tag_err=0.
- Reset asserted mid-operation drops the buffered request and all in-flight accounting; late responses after reset set tag_err.
- Reset outputs: vfu_valid=0, req_ready=0, slot_resp_valid=0, idle=1, tag_err=0.
- Eligibility: elig[i] = req_valid[i] && outstanding[i] < MAX_OUT.
- Grant: one-hot, first eligible slot searching rr_ptr, rr_ptr+1, ... modulo NUM_SLOTS.
- can_load = !out_valid || vfu_ready (the output stage drains and refills in the same cycle).
- req_ready[i] = grant[i] && can_load. At most one bit is set. req_ready may depend combinationally on req_valid.
- Accept (req_valid[i] && req_ready[i]) has these effects:
  - out_bits <= slot i payload, out_tag <= i, out_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_SLOTS.
  - outstanding[i] increments.
- vfu_valid = out_valid, vfu_bits = out_bits, vfu_tag = out_tag.
- Latency: accept to vfu_valid is 1 cycle. Sustained throughput is 1 request/cycle while vfu_ready=1.
- Output stage holds: if vfu_ready=0 and out_valid=1, payload and tag stay stable; no accept occurs.
- If out_valid=1, vfu_ready=1 and no accept occurs, out_valid <= 0 next cycle.
- rr_ptr is unchanged in cycles without an accept.
- Outstanding counting:
  - outstanding[i] counts accepted requests whose response has not returned; it includes the request held in the output stage.
  - Width: clog2(MAX_OUT+1).
- Response handling:
  - slot_resp_valid[i] = resp_valid && resp_tag==i (combinational, zero latency).
  - On the clock edge, outstanding[resp_tag] decrements.
  - Accept and response for the same slot in the same cycle: count unchanged.
  - Response to a slot with count 0: count stays 0, tag_err <= 1 (sticky until reset).
  - resp_tag >= NUM_SLOTS: no strobe, tag_err <= 1.
- A slot at MAX_OUT is skipped by the arbiter. The arbiter still grants other eligible slots in the same cycle; there is no head-of-line blocking.
- idle = !out_valid && all outstanding==0 (combinational from registers).
- No internal FSM beyond the output-stage valid bit, rr_ptr and counters.

Decomposition:
- Shared package vfu_sched_pkg holds:
  - the TAG_W derivation function;
  - the slot request struct typedef (src_0..src_3[32:0], opcode, mask, executeMask, control bits, groupIndex, laneIndex, etc.) whose packed width is REQ_W;
  - the outstanding-counter width function.
- One sub-module: rr_arbiter (NUM_SLOTS), inputs elig and rr_ptr, output one-hot grant plus encoded index. It is purely combinational and reusable by other VFU schedulers.

Test Plan:
- Single slot, NUM_SLOTS=4, vfu_ready=1: slot 2 request with payload 0xABC accepted at cycle 0 -> next cycle vfu_valid=1, vfu_bits=0xABC, vfu_tag=2; idle=0 until resp_tag=2 returns; slot_resp_valid=4'b0100 that cycle; idle=1 after.
- All 4 slots valid continuously, vfu_ready=1, responses returned 1 cycle after VFU accept: accept order 0,1,2,3,0,... with one accept per cycle; no slot starved.
- Backpressure: vfu_ready=0 for 5 cycles with out_valid=1 -> vfu_bits/vfu_tag stable, req_ready=0; vfu_ready=1 -> drain and refill in the same cycle.
- MAX_OUT=2, slot 0 gets no responses: after 2 accepts slot 0 is skipped, slot 1 is still granted; a response tag 0 in the same cycle as slot 0 re-eligibility gives accept the next cycle with count returning to 2.
- Simultaneous accept and response for slot 1 at count 1 -> count stays 1. A response for slot 3 at count 0 -> tag_err=1, held until reset.
- Reset asserted while out_valid=1 and counts are nonzero -> next cycle vfu_valid=0, idle=1, rr_ptr=0, tag_err=0.

Source files
------------

// File: rtl/vfu_sched_pkg.sv
// Shared types and width helpers for the VFU slot schedulers.
// The slot request struct documents the flattened payload layout.
package vfu_sched_pkg;

  typedef struct packed {
    logic [32:0] src_0;
    logic [32:0] src_1;
    logic [32:0] src_2;
    logic [32:0] src_3;
    logic [7:0]  opcode;
    logic [15:0] mask;
    logic [15:0] execute_mask;
    logic [7:0]  group_index;
    logic [3:0]  lane_index;
    logic [1:0]  sew;
    logic [7:0]  vl;
    logic [5:0]  ctrl;
  } slot_req_t;

  localparam int SLOT_REQ_W = $bits(slot_req_t);

  // A single slot still needs a one-bit tag so vfu_tag/resp_tag exist.
  function automatic int tag_width(input int num_slots);
    return (num_slots <= 2) ? 1 : $clog2(num_slots);
  endfunction

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/vfu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible slot at or after rr_ptr.
module rr_arbiter #(
  parameter int NUM_SLOTS = 4,
  parameter int TAG_W     = 2
) (
  input  logic [NUM_SLOTS-1:0] elig,
  input  logic [TAG_W-1:0]     rr_ptr,
  output logic [NUM_SLOTS-1:0] grant,
  output logic [TAG_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  int slot;

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    slot        = 0;
    for (int off = 0; off < NUM_SLOTS; off++) begin
      slot = (int'(rr_ptr) + off) % NUM_SLOTS;
      if (!grant_valid && elig[slot]) begin
        grant_valid = 1'b1;
        grant[slot] = 1'b1;
        grant_idx   = TAG_W'(slot);
      end
    end
  end

endmodule

// File: rtl/vfu_slot_scheduler.sv
// Shares one VFU request port among NUM_SLOTS slots: round-robin grant,
// per-slot in-flight cap, one-entry output stage, tag-steered responses.
module vfu_slot_scheduler
  import vfu_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int REQ_W     = SLOT_REQ_W,
  parameter int RESP_W    = 33,
  parameter int MAX_OUT   = 2,
  parameter int TAG_W     = tag_width(NUM_SLOTS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SLOTS-1:0]       req_valid,
  output logic [NUM_SLOTS-1:0]       req_ready,
  input  logic [NUM_SLOTS*REQ_W-1:0] req_bits,
  output logic                       vfu_valid,
  input  logic                       vfu_ready,
  output logic [REQ_W-1:0]           vfu_bits,
  output logic [TAG_W-1:0]           vfu_tag,
  input  logic                       resp_valid,
  input  logic [TAG_W-1:0]           resp_tag,
  input  logic [RESP_W-1:0]          resp_data,
  output logic [NUM_SLOTS-1:0]       slot_resp_valid,
  output logic [RESP_W-1:0]          slot_resp_data,
  output logic                       idle,
  output logic                       tag_err
);

  localparam int CNT_W = cnt_width(MAX_OUT);

  logic                 out_valid;
  logic [REQ_W-1:0]     out_bits;
  logic [TAG_W-1:0]     out_tag;
  logic [TAG_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     outstanding [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] elig;
  logic [NUM_SLOTS-1:0] grant;
  logic [TAG_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 can_load;
  logic                 accept;
  logic [REQ_W-1:0]     sel_bits;
  logic [NUM_SLOTS-1:0] resp_hit;
  logic                 resp_err;
  logic                 all_zero;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      elig[i] = req_valid[i] && (outstanding[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .NUM_SLOTS (NUM_SLOTS),
    .TAG_W     (TAG_W)
  ) u_arb (
    .elig        (elig),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign can_load  = !out_valid || vfu_ready;
  assign accept    = reset && grant_valid && can_load;
  assign req_ready = grant & {NUM_SLOTS{reset && can_load}};

  always_comb begin
    sel_bits = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (grant[i]) sel_bits = req_bits[i*REQ_W +: REQ_W];
    end
  end

  // A response with no matching in-flight request (or an out-of-range tag) is an error.
  always_comb begin
    resp_hit = '0;
    resp_err = 1'b0;
    if (resp_valid) begin
      resp_err = 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (resp_tag == TAG_W'(i)) begin
          resp_hit[i] = 1'b1;
          resp_err    = (outstanding[i] == '0);
        end
      end
    end
  end

  assign slot_resp_valid = resp_hit & {NUM_SLOTS{reset}};
  assign slot_resp_data  = resp_data;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (outstanding[i] != '0) all_zero = 1'b0;
    end
  end

  assign idle      = !out_valid && all_zero;
  assign vfu_valid = out_valid;
  assign vfu_bits  = out_bits;
  assign vfu_tag   = out_tag;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_tag   <= '0;
      rr_ptr    <= '0;
      tag_err   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) outstanding[i] <= '0;
    end else begin
      if (can_load) begin
        out_valid <= accept;
        if (accept) begin
          out_bits <= sel_bits;
          out_tag  <= grant_idx;
          rr_ptr   <= (grant_idx == TAG_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
      end
      if (resp_err) tag_err <= 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        // Decrement only a nonzero count; simultaneous inc and dec cancel.
        if ((accept && grant[i]) && !(resp_hit[i] && outstanding[i] != '0)) begin
          outstanding[i] <= outstanding[i] + CNT_W'(1);
        end else if (!(accept && grant[i]) && resp_hit[i] && outstanding[i] != '0) begin
          outstanding[i] <= outstanding[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vfu_slot_scheduler.sv
// Directed bench for vfu_slot_scheduler with a per-cycle reference model.
module tb_vfu_slot_scheduler;

  localparam int N  = 4;
  localparam int RW = 200;
  localparam int DW = 33;
  localparam int MO = 2;
  localparam int TW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_bits;
  logic            vfu_valid;
  logic            vfu_ready;
  logic [RW-1:0]   vfu_bits;
  logic [TW-1:0]   vfu_tag;
  logic            resp_valid;
  logic [TW-1:0]   resp_tag;
  logic [DW-1:0]   resp_data;
  logic [N-1:0]    slot_resp_valid;
  logic [DW-1:0]   slot_resp_data;
  logic            idle;
  logic            tag_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vfu_slot_scheduler #(
    .NUM_SLOTS (N),
    .REQ_W     (RW),
    .RESP_W    (DW),
    .MAX_OUT   (MO),
    .TAG_W     (TW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_bits        (req_bits),
    .vfu_valid       (vfu_valid),
    .vfu_ready       (vfu_ready),
    .vfu_bits        (vfu_bits),
    .vfu_tag         (vfu_tag),
    .resp_valid      (resp_valid),
    .resp_tag        (resp_tag),
    .resp_data       (resp_data),
    .slot_resp_valid (slot_resp_valid),
    .slot_resp_data  (slot_resp_data),
    .idle            (idle),
    .tag_err         (tag_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue-stage flag, per-slot in-flight counts, a pointer.
  bit            m_on = 1'b0;
  bit            m_valid;
  logic [RW-1:0] m_bits;
  int            m_tag;
  int            m_ptr;
  int            m_cnt [N];
  bit            m_err;

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr + k) % N;
      if (req_valid[s] && m_cnt[s] < MO) return s;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_on    = 1'b1;
      m_valid = 1'b0;
      m_bits  = '0;
      m_tag   = 0;
      m_ptr   = 0;
      m_err   = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_on) begin
      int  g;
      int  dec;
      bit  room;
      bit  acc;
      g    = m_pick();
      room = !m_valid || vfu_ready;
      acc  = room && (g >= 0);
      dec  = -1;
      if (resp_valid) begin
        if (int'(resp_tag) >= N || m_cnt[resp_tag] == 0) m_err = 1'b1;
        else dec = int'(resp_tag);
      end
      if (acc) m_cnt[g]++;
      if (dec >= 0) m_cnt[dec]--;
      if (room) begin
        m_valid = acc;
        if (acc) begin
          m_bits = req_bits[g*RW +: RW];
          m_tag  = g;
          m_ptr  = (g + 1) % N;
        end
      end
    end
  end

  always @(negedge clock) begin
    #3;
    if (m_on) begin
      int          g;
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_strobe;
      bit          exp_idle;
      g          = m_pick();
      exp_ready  = '0;
      exp_strobe = '0;
      if (reset && (!m_valid || vfu_ready) && g >= 0) exp_ready[g] = 1'b1;
      if (reset && resp_valid && int'(resp_tag) < N) exp_strobe[resp_tag] = 1'b1;
      exp_idle = !m_valid;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_idle = 1'b0;
      check("req_ready", req_ready, exp_ready);
      check("vfu_valid", vfu_valid, m_valid);
      if (m_valid) begin
        check("vfu_bits", vfu_bits, m_bits);
        check("vfu_tag", vfu_tag, m_tag[TW-1:0]);
      end
      check("slot_resp_valid", slot_resp_valid, exp_strobe);
      check("slot_resp_data", slot_resp_data, resp_data);
      check("idle", idle, exp_idle);
      check("tag_err", tag_err, m_err);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_payload(input int s, input logic [RW-1:0] v);
    req_bits[s*RW +: RW] = v;
  endtask

  task automatic respond(input bit v, input int t);
    resp_valid = v;
    resp_tag   = TW'(t);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  dut_log [$];
    bit  hs;
    int  hs_tag;

    reset      = 1'b0;
    req_valid  = '0;
    req_bits   = '0;
    vfu_ready  = 1'b1;
    resp_valid = 1'b0;
    resp_tag   = '0;
    resp_data  = '0;
    tick();
    do_reset();
    settle();
    check("rst_vfu_valid", vfu_valid, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_tag_err", tag_err, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);

    // Single request from slot 2
    set_payload(2, 200'hABC);
    req_valid = 4'b0100;
    settle();
    check("t1_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    settle();
    check("t1_vfu_valid", vfu_valid, 1'b1);
    check("t1_vfu_bits", vfu_bits, 200'hABC);
    check("t1_vfu_tag", vfu_tag, 2'd2);
    check("t1_idle_busy", idle, 1'b0);
    tick();
    settle();
    check("t1_drained", vfu_valid, 1'b0);
    check("t1_idle_inflight", idle, 1'b0);
    respond(1'b1, 2);
    resp_data = 33'h1_2345_6789;
    settle();
    check("t1_strobe", slot_resp_valid, 4'b0100);
    check("t1_resp_data", slot_resp_data, 33'h1_2345_6789);
    tick();
    respond(1'b0, 0);
    settle();
    check("t1_idle_after", idle, 1'b1);

    // All slots continuously valid, responses one cycle after handshake
    do_reset();
    for (int s = 0; s < N; s++) set_payload(s, RW'(32'h1000 + s));
    hs = 1'b0;
    hs_tag = 0;
    for (int c = 0; c < 15; c++) begin
      req_valid = (c < 12) ? 4'b1111 : 4'b0000;
      respond(hs, hs_tag);
      resp_data = DW'(c);
      settle();
      for (int s = 0; s < N; s++) if (req_ready[s]) dut_log.push_back(s);
      hs     = vfu_valid && vfu_ready;
      hs_tag = int'(vfu_tag);
      tick();
    end
    respond(1'b0, 0);
    check("t2_accept_count", dut_log.size(), 12);
    for (int k = 0; k < dut_log.size() && k < 12; k++) begin
      check($sformatf("t2_order_%0d", k), dut_log[k], k % 4);
    end
    settle();
    check("t2_idle", idle, 1'b1);

    // Backpressure: hold slot 1 while slot 3 waits
    set_payload(1, 200'h111);
    set_payload(3, 200'h333);
    req_valid = 4'b0010;
    tick();
    vfu_ready = 1'b0;
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("t3_hold_bits", vfu_bits, 200'h111);
      check("t3_hold_tag", vfu_tag, 2'd1);
      check("t3_hold_ready", req_ready, 4'b0000);
      tick();
    end
    vfu_ready = 1'b1;
    settle();
    check("t3_refill_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    respond(1'b1, 1);
    settle();
    check("t3_new_tag", vfu_tag, 2'd3);
    check("t3_new_bits", vfu_bits, 200'h333);
    tick();
    respond(1'b1, 3);
    tick();
    respond(1'b0, 0);
    settle();
    check("t3_idle", idle, 1'b1);

    // In-flight cap on slot 0, no head-of-line blocking
    req_valid = 4'b0001;
    settle();
    check("t4_a", req_ready, 4'b0001);
    tick();
    settle();
    check("t4_b", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0011;
    settle();
    check("t4_skip0", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0001;
    settle();
    check("t4_capped", req_ready, 4'b0000);
    tick();
    respond(1'b1, 0);
    settle();
    check("t4_resp_same_cycle", req_ready, 4'b0000);
    tick();
    respond(1'b1, 1);
    settle();
    check("t4_reeligible", req_ready, 4'b0001);
    tick();
    respond(1'b0, 0);
    settle();
    check("t4_capped_again", req_ready, 4'b0000);
    check("t4_no_err", tag_err, 1'b0);
    tick();
    req_valid = '0;
    respond(1'b1, 0);
    tick();
    respond(1'b1, 0);
    tick();
    respond(1'b0, 0);
    settle();
    check("t4_idle", idle, 1'b1);
    check("t4_no_err_end", tag_err, 1'b0);

    // Simultaneous accept and response on slot 1, then a stray response
    req_valid = 4'b0010;
    settle();
    check("t5_first", req_ready, 4'b0010);
    tick();
    respond(1'b1, 1);
    settle();
    check("t5_second", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    respond(1'b0, 0);
    settle();
    check("t5_idle", idle, 1'b1);
    check("t5_no_err", tag_err, 1'b0);
    respond(1'b1, 3);
    settle();
    check("t5_stray_strobe", slot_resp_valid, 4'b1000);
    tick();
    respond(1'b0, 0);
    settle();
    check("t5_tag_err", tag_err, 1'b1);
    tick();
    tick();
    tick();
    check("t5_tag_err_sticky", tag_err, 1'b1);

    // Reset while busy
    req_valid = 4'b0011;
    tick();
    tick();
    settle();
    check("t6_busy", idle, 1'b0);
    reset = 1'b0;
    settle();
    check("t6_ready_in_reset", req_ready, 4'b0000);
    tick();
    settle();
    check("t6_vfu_valid", vfu_valid, 1'b0);
    check("t6_idle", idle, 1'b1);
    check("t6_tag_err", tag_err, 1'b0);
    reset = 1'b1;
    req_valid = 4'b1111;
    settle();
    check("t6_ptr_zero", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    respond(1'b1, 1);
    tick();
    respond(1'b0, 0);
    settle();
    check("t6_late_resp_err", tag_err, 1'b1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
